rv_pc_unit: RTL and testbench
=============================

Name: rv_pc_unit

Overview:
- Parametrised program-counter / next-PC unit for the RV core. Generalises the basic PC in four ways:
  - configurable XLEN and reset vector;
  - compressed-instruction stepping (IALIGN=16);
  - trap entry through an mtvec-style base in direct or vectored mode, with EPC capture;
  - mret return and misaligned-jump-target exception detection.
- Sits between the decode/branch logic and the instruction-memory address port.

Parameters:
- XLEN, 32, width of the PC, EPC and all address ports.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- IALIGN, 32, instruction alignment in bits. Legal values are 16 or 32. At 32, inst_len16 is ignored.
- CAUSE_W, 5, width of trap_cause.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous active-high reset
- hlt  in  1  freeze PC, EPC and state while high
- pc_sel  in  1  1 = redirect to pc_in (branch/jump taken)
- pc_in  in  XLEN  redirect target
- inst_len16  in  1  current instruction is 16-bit; step is 2 instead of 4 (only when IALIGN=16)
- trap_req  in  1  take trap this cycle
- trap_irq  in  1  trap is an interrupt; qualifies vectored mode
- trap_cause  in  CAUSE_W  trap cause code
- mtvec_base  in  XLEN  trap vector base; bits [1:0] are ignored
- mtvec_mode  in  1  0 = direct, 1 = vectored
- mret  in  1  return from trap to EPC
- pc_curr  out  XLEN  current PC (instruction fetch address)
- pc_next  out  XLEN  sequential next PC (link value for JAL/JALR)
- epc  out  XLEN  saved exception PC
- trap_taken  out  1  one-cycle pulse on the cycle the PC loads a trap vector
- misalign_err  out  1  one-cycle pulse when a redirect target is misaligned
- in_trap  out  1  state flag: high from trap entry until mret

Behaviour:
- Everything is registered on the posedge of sys_clk. Each redirect takes effect on pc_curr one cycle after it is presented. There are no combinational paths from the control inputs to pc_curr.
- Reset state (sys_rst=1, overrides all inputs including hlt):
  - pc_curr = RESET_VECTOR, epc = 0, in_trap = 0;
  - trap_taken = 0, misalign_err = 0.
- Sequential step and link value:
  - step = 2 when IALIGN=16 and inst_len16=1; otherwise step = 4.
  - pc_next = pc_curr + step. It is combinational and wraps modulo 2^XLEN (0xFFFF_FFFC + 4 = 0).
- Misalignment: when pc_sel=1, pc_in is misaligned if
  - IALIGN=32 and pc_in[1:0] != 0, or
  - IALIGN=16 and pc_in[0] != 0.
- Vector address:
  - vec = {mtvec_base[XLEN-1:2], 2'b00}.
  - If mtvec_mode=1 and trap_irq=1, add 4*trap_cause to vec; otherwise use vec as is.
- Next-state priority when hlt=0, highest first:
  1. trap_req: epc <= pc_curr; pc <= vec; in_trap <= 1; trap_taken pulses.
  2. mret (only acted on when in_trap=1): pc <= epc; in_trap <= 0. When in_trap=0, mret is ignored and the step is sequential.
  3. pc_sel with a misaligned pc_in:
     - no redirect; epc <= pc_curr; pc <= vec computed with cause 0 (instruction-address-misaligned), direct form regardless of trap_irq;
     - in_trap <= 1; misalign_err and trap_taken both pulse.
  4. pc_sel with an aligned pc_in: pc <= pc_in.
  5. Otherwise: pc <= pc_curr + step.
- Simultaneous events:
  - trap_req together with pc_sel or mret: the trap wins; the others are dropped.
  - mret together with pc_sel: mret wins.
- Nested trap while in_trap=1: taken normally. EPC is overwritten and in_trap stays 1. There is no nesting stack.
- hlt=1:
  - PC, EPC and in_trap hold; trap_taken and misalign_err stay 0.
  - Requests presented during hlt are not latched. Requesters hold them until hlt falls.
- sys_rst asserted mid-trap or mid-halt: returns to the reset state on the next edge.
- State machine: two states, RUN (in_trap=0) and TRAP (in_trap=1).
  - RUN -> TRAP on a trap or misaligned redirect.
  - TRAP -> RUN on mret.
  - TRAP -> TRAP on a nested trap.

Test Plan:
- Reset/sequential: RESET_VECTOR=0x100, release reset, 3 idle cycles -> pc_curr 0x100, 0x104, 0x108, 0x10C; pc_next = pc_curr+4 each cycle.
- Branch and halt: at pc 0x10, pc_sel=1, pc_in=0x200 -> next pc 0x200. Then hlt=1 for 3 cycles with pc_sel=1, pc_in=0x400 -> pc stays 0x200; after hlt drops with pc_sel=0 -> 0x204.
- Vectored interrupt and return, with mtvec_base=0x8000_0001, mtvec_mode=1:
  - at pc 0x40, trap_req=1, trap_irq=1, cause=7 -> pc 0x8000_001C, epc 0x40, trap_taken pulse, in_trap=1;
  - then mret -> pc 0x40, in_trap=0.
- Misaligned target: IALIGN=32, mtvec_base=0x300, at pc 0x50, pc_sel=1, pc_in=0x602 -> pc 0x300, epc 0x50, misalign_err and trap_taken each pulse once. IALIGN=16, pc_in=0x602 -> pc 0x602, no error.
- Compressed step and wrap:
  - IALIGN=16, inst_len16=1 from pc 0x1000 -> 0x1002; inst_len16=0 -> 0x1006.
  - Start pc 0xFFFF_FFFC, sequential step -> 0x0000_0000.
- Priority and reset:
  - trap_req, mret and pc_sel asserted together -> trap vector taken.
  - mret with in_trap=0 -> pc+4.
  - sys_rst asserted while in_trap=1 and hlt=1 -> pc RESET_VECTOR, epc 0, in_trap 0 next cycle.

Source files
------------

// File: rtl/rv_pc_unit.sv
// rv_pc_unit: program counter / next-PC unit with compressed stepping,
// mtvec trap entry, EPC capture, mret return and misaligned-target traps.
module rv_pc_unit #(
  parameter int               XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int               IALIGN       = 32,
  parameter int               CAUSE_W      = 5
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               hlt,
  input  logic               pc_sel,
  input  logic [XLEN-1:0]    pc_in,
  input  logic               inst_len16,
  input  logic               trap_req,
  input  logic               trap_irq,
  input  logic [CAUSE_W-1:0] trap_cause,
  input  logic [XLEN-1:0]    mtvec_base,
  input  logic               mtvec_mode,
  input  logic               mret,
  output logic [XLEN-1:0]    pc_curr,
  output logic [XLEN-1:0]    pc_next,
  output logic [XLEN-1:0]    epc,
  output logic               trap_taken,
  output logic               misalign_err,
  output logic               in_trap
);

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            tt_q, tt_d;
  logic            me_q, me_d;

  logic [XLEN-1:0] step;
  logic [XLEN-1:0] vec_base;
  logic [XLEN-1:0] cause_off;
  logic [XLEN-1:0] vec;
  logic            misalign;

  assign step = ((IALIGN == 16) && inst_len16)
              ? XLEN'(2) : XLEN'(4);

  assign pc_next = pc_q + step;

  assign vec_base  = mtvec_base & {{(XLEN-2){1'b1}}, 2'b00};
  assign cause_off = XLEN'(trap_cause) << 2;
  assign vec       = (mtvec_mode && trap_irq)
                   ? vec_base + cause_off : vec_base;

  // With compressed support only bit 0 must be clear.
  assign misalign = (IALIGN == 16) ? pc_in[0]
                                   : |pc_in[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    tt_d    = 1'b0;
    me_d    = 1'b0;
    if (!hlt) begin
      priority case (1'b1)
        trap_req: begin
          epc_d   = pc_q;
          pc_d    = vec;
          state_d = TRAP;
          tt_d    = 1'b1;
        end
        (mret && state_q == TRAP): begin
          pc_d    = epc_q;
          state_d = RUN;
        end
        (pc_sel && misalign): begin
          epc_d   = pc_q;
          pc_d    = vec_base;
          state_d = TRAP;
          tt_d    = 1'b1;
          me_d    = 1'b1;
        end
        pc_sel: begin
          pc_d = pc_in;
        end
        default: begin
          pc_d = pc_q + step;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      tt_q    <= 1'b0;
      me_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      tt_q    <= tt_d;
      me_q    <= me_d;
    end
  end

  assign pc_curr      = pc_q;
  assign epc          = epc_q;
  assign trap_taken   = tt_q;
  assign misalign_err = me_q;
  assign in_trap      = (state_q == TRAP);

endmodule

// File: tb/tb_rv_pc_unit.sv
// tb_rv_pc_unit: scoreboard bench driving an IALIGN=32 and an IALIGN=16
// instance with shared stimulus against a behavioural PC model.
module tb_rv_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0100;

  typedef struct {
    logic        rst;
    logic        hlt;
    logic        sel;
    logic [31:0] pcin;
    logic        len16;
    logic        treq;
    logic        tirq;
    logic [4:0]  cause;
    logic [31:0] mbase;
    logic        mmode;
    logic        mret;
  } in_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic        it;
    logic        tt;
    logic        me;
  } st_t;

  typedef struct {
    st_t         s;
    logic [31:0] pcn;
  } exp_t;

  logic sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  in_t drv;
  st_t m32, m16;
  exp_t q32[$];
  exp_t q16[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] pc_a, pcn_a, epc_a;
  logic        tt_a, me_a, it_a;
  logic [31:0] pc_b, pcn_b, epc_b;
  logic        tt_b, me_b, it_b;

  rv_pc_unit #(
    .XLEN(32), .RESET_VECTOR(RV), .IALIGN(32), .CAUSE_W(5)
  ) dut32 (
    .sys_clk(sys_clk), .sys_rst(drv.rst), .hlt(drv.hlt),
    .pc_sel(drv.sel), .pc_in(drv.pcin), .inst_len16(drv.len16),
    .trap_req(drv.treq), .trap_irq(drv.tirq),
    .trap_cause(drv.cause), .mtvec_base(drv.mbase),
    .mtvec_mode(drv.mmode), .mret(drv.mret),
    .pc_curr(pc_a), .pc_next(pcn_a), .epc(epc_a),
    .trap_taken(tt_a), .misalign_err(me_a), .in_trap(it_a)
  );

  rv_pc_unit #(
    .XLEN(32), .RESET_VECTOR(RV), .IALIGN(16), .CAUSE_W(5)
  ) dut16 (
    .sys_clk(sys_clk), .sys_rst(drv.rst), .hlt(drv.hlt),
    .pc_sel(drv.sel), .pc_in(drv.pcin), .inst_len16(drv.len16),
    .trap_req(drv.treq), .trap_irq(drv.tirq),
    .trap_cause(drv.cause), .mtvec_base(drv.mbase),
    .mtvec_mode(drv.mmode), .mret(drv.mret),
    .pc_curr(pc_b), .pc_next(pcn_b), .epc(epc_b),
    .trap_taken(tt_b), .misalign_err(me_b), .in_trap(it_b)
  );

  function automatic logic [31:0] step_of(int ia, in_t x);
    return (ia == 16 && x.len16) ? 32'd2 : 32'd4;
  endfunction

  function automatic st_t model(int ia, st_t s, in_t x);
    st_t n;
    logic [31:0] base;
    logic bad;
    n = s;
    n.tt = 1'b0;
    n.me = 1'b0;
    base = x.mbase & 32'hFFFF_FFFC;
    bad = (ia == 16) ? (x.pcin % 2 != 0) : (x.pcin % 4 != 0);
    if (x.rst) begin
      n.pc = RV; n.epc = 0; n.it = 0;
    end else if (x.hlt) begin
      n = n;
    end else if (x.treq) begin
      n.epc = s.pc; n.it = 1; n.tt = 1;
      n.pc = base + ((x.mmode && x.tirq) ? 32'(x.cause) * 4 : 0);
    end else if (x.mret && s.it) begin
      n.pc = s.epc; n.it = 0;
    end else if (x.sel && bad) begin
      n.epc = s.pc; n.pc = base; n.it = 1; n.tt = 1; n.me = 1;
    end else if (x.sel) begin
      n.pc = x.pcin;
    end else begin
      n.pc = s.pc + step_of(ia, x);
    end
    return n;
  endfunction

  function automatic in_t idle();
    in_t x;
    x = '{default: '0};
    x.mbase = 32'h0000_0300;
    return x;
  endfunction

  task automatic cycle(input in_t x);
    exp_t e;
    drv = x;
    e.s = m32; e.pcn = m32.pc + step_of(32, x); q32.push_back(e);
    e.s = m16; e.pcn = m16.pc + step_of(16, x); q16.push_back(e);
    m32 = model(32, m32, x);
    m16 = model(16, m16, x);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    exp_t e;
    if (q32.size() > 0) begin
      e = q32.pop_front();
      chk("a.pc_curr", pc_a, e.s.pc);
      chk("a.pc_next", pcn_a, e.pcn);
      chk("a.epc", epc_a, e.s.epc);
      chk("a.in_trap", 32'(it_a), 32'(e.s.it));
      chk("a.trap_taken", 32'(tt_a), 32'(e.s.tt));
      chk("a.misalign_err", 32'(me_a), 32'(e.s.me));
    end
    if (q16.size() > 0) begin
      e = q16.pop_front();
      chk("b.pc_curr", pc_b, e.s.pc);
      chk("b.pc_next", pcn_b, e.pcn);
      chk("b.epc", epc_b, e.s.epc);
      chk("b.in_trap", 32'(it_b), 32'(e.s.it));
      chk("b.trap_taken", 32'(tt_b), 32'(e.s.tt));
      chk("b.misalign_err", 32'(me_b), 32'(e.s.me));
    end
  end

  function automatic in_t rnd();
    in_t x;
    x = idle();
    x.mbase = $urandom;
    x.mmode = 1'($urandom_range(0, 1));
    x.tirq  = 1'($urandom_range(0, 1));
    x.cause = 5'($urandom);
    x.len16 = 1'($urandom_range(0, 1));
    x.treq  = ($urandom_range(0, 9) == 0);
    x.mret  = ($urandom_range(0, 4) == 0);
    x.sel   = ($urandom_range(0, 3) == 0);
    x.pcin  = $urandom;
    if ($urandom_range(0, 3) != 0) x.pcin[1:0] = 2'b00;
    x.hlt   = ($urandom_range(0, 7) == 0);
    x.rst   = ($urandom_range(0, 63) == 0);
    return x;
  endfunction

  initial begin
    in_t x;
    drv = idle();
    drv.rst = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    m32 = '{pc: RV, epc: 0, it: 0, tt: 0, me: 0};
    m16 = m32;
    x = idle();
    cycle(x);
    repeat (3) cycle(idle());

    x = idle(); x.sel = 1; x.pcin = 32'h10; cycle(x);
    x.pcin = 32'h200; cycle(x);
    x.hlt = 1; x.pcin = 32'h400;
    repeat (3) cycle(x);
    repeat (2) cycle(idle());

    x = idle(); x.mbase = 32'h8000_0001; x.mmode = 1;
    x.sel = 1; x.pcin = 32'h40; cycle(x);
    x.sel = 0; x.treq = 1; x.tirq = 1; x.cause = 5'd7; cycle(x);
    x.treq = 0; x.tirq = 0; cycle(x);
    x.mret = 1; cycle(x);
    x.mret = 0; cycle(x);

    x = idle(); x.sel = 1; x.pcin = 32'h50; cycle(x);
    x.pcin = 32'h602; cycle(x);
    repeat (2) cycle(idle());

    x = idle(); x.sel = 1; x.pcin = 32'h1000; cycle(x);
    x = idle(); x.len16 = 1; cycle(x);
    x.len16 = 0; cycle(x);
    cycle(x);

    x = idle(); x.sel = 1; x.pcin = 32'hFFFF_FFFC; cycle(x);
    repeat (2) cycle(idle());

    x = idle(); x.treq = 1; cycle(x);
    x.mret = 1; x.sel = 1; x.pcin = 32'h80; cycle(x);
    x = idle(); x.mret = 1; cycle(x);
    cycle(x);
    cycle(idle());

    x = idle(); x.treq = 1; x.cause = 5'd3; cycle(x);
    x = idle(); x.hlt = 1; cycle(x);
    x.rst = 1; cycle(x);
    repeat (2) cycle(idle());

    for (int i = 0; i < 400; i++) cycle(rnd());
    cycle(idle());

    @(negedge sys_clk);
    #1;
    chk("queue_drained", 32'(q32.size() + q16.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
